// File: rtl/soc_mem_arbiter_if.sv
// Core-side and memory-side signals of the shared-memory arbiter.
// The slave modport is the arbiter's view; master is the core plus memory.
interface soc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              stall;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall,
               mem_ce, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall,
               mem_ce, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
// One access in flight at a time: IDLE -> ISSUE -> WAIT x MEM_LAT -> DONE.
module soc_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int DATA_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    soc_mem_arbiter_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1 || (DATA_W % 8) != 0) begin : gBadParam
            $error("soc_mem_arbiter: MEM_LAT must be >= 1 and DATA_W a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    stateT             state, stateNxt;
    logic [CNT_W-1:0]  cnt;
    logic              winData;    // latched winner: 1 = data port
    logic              winWrite;
    logic              lastData;   // last grantee, for round-robin
    logic              anyReq, pickData, grant;

    logic              memCe, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [BE_W-1:0]   memBe;
    logic [DATA_W-1:0] ifRdata, dmRdata;
    logic              ifAck, dmAck, stall;

    assign anyReq   = bus.if_req | bus.dm_req;
    assign pickData = bus.dm_req & (~bus.if_req | (DATA_PRIO != 0) | ~lastData);
    assign grant    = (state == IDLE) & anyReq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (anyReq) stateNxt = ISSUE;
            ISSUE:   stateNxt = WAIT;
            WAIT:    if (cnt == CNT_W'(1)) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // stall is forced low while reset is held, even with requests pending
    always_comb begin
        ifAck = (state == DONE) & ~winData;
        dmAck = (state == DONE) &  winData;
        stall = rst & ((bus.if_req & ~ifAck) | (bus.dm_req & ~dmAck));
    end

    // Memory-side outputs are loaded at grant and live for the ISSUE cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            winData  <= 1'b0;
            winWrite <= 1'b0;
            lastData <= 1'b1;
            memCe    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= '0;
            ifRdata  <= '0;
            dmRdata  <= '0;
        end else begin
            memCe    <= grant;
            memWe    <= grant & pickData & bus.dm_we;
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= '0;
            if (grant) begin
                winData  <= pickData;
                lastData <= pickData;
                winWrite <= pickData & bus.dm_we;
                memAddr  <= pickData ? bus.dm_addr : bus.if_addr;
                memBe    <= '1;
                if (pickData && bus.dm_we) begin
                    memWdata <= bus.dm_wdata;
                    memBe    <= bus.dm_be;
                end
            end
            if (state == ISSUE)     cnt <= CNT_W'(MEM_LAT);
            else if (state == WAIT) cnt <= cnt - CNT_W'(1);
            if (state == WAIT && cnt == CNT_W'(1) && !winWrite) begin
                if (winData) dmRdata <= bus.mem_rdata;
                else         ifRdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_rdata  = ifRdata;
    assign bus.if_ack    = ifAck;
    assign bus.dm_rdata  = dmRdata;
    assign bus.dm_ack    = dmAck;
    assign bus.stall     = stall;
    assign bus.mem_ce    = memCe;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.mem_be    = memBe;
endmodule

// File: doc/soc_mem_arbiter.md
Name: soc_mem_arbiter

Overview:
Parametrised shared-memory arbiter for the next-generation SOC top. It lets the MIPS core's instruction-fetch port and data port share one single-port memory with configurable fixed latency. This replaces the direct InstMem/DataMem wiring. It adds a req/ack handshake, byte enables, a selectable arbitration policy and a core stall output.

Parameters:
ADDR_W, 32, address width of both requester ports and the memory port
DATA_W, 32, data width; must be a multiple of 8
MEM_LAT, 1, memory read/write latency in cycles from mem_ce to data/completion; must be >=1 (0 is an elaboration error)
DATA_PRIO, 1, 1 = data port has fixed priority; 0 = round-robin between ports

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_rdata  out  DATA_W  fetched instruction; valid with if_ack, held until the next if_ack
if_ack  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held high until dm_ack
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_be  in  DATA_W/8  byte enables for writes
dm_rdata  out  DATA_W  read data; valid with dm_ack, held until the next dm_ack
dm_ack  out  1  one-cycle completion pulse for data
stall  out  1  pipeline stall to core
mem_ce  out  1  memory chip enable, one-cycle pulse per access
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables; all ones for reads
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_ce

Behaviour:
- Reset (rst=0, async): state IDLE; counter 0; every output 0; last-grantee register = DATA.
- States:
  - IDLE: samples requests. If any request is present, latch the winner and go to ISSUE.
  - ISSUE: one cycle. Registered mem_ce=1 and mem_we/addr/wdata/be from the latched request; counter loads MEM_LAT.
  - WAIT: counter decrements each cycle. When it reaches 0, capture mem_rdata into the winner's rdata register (reads only) and go to DONE.
  - DONE: winner's ack=1 for exactly this cycle, then back to IDLE. Requests are not sampled in DONE, which masks the still-high req of the acked port.
- Latency: request first high in IDLE at cycle N -> mem_ce at N+1 -> ack at N+2+MEM_LAT. Peak throughput is one access per MEM_LAT+3 cycles.
- Arbitration when both requests are present in IDLE:
  - DATA_PRIO=1: data port wins.
  - DATA_PRIO=0: the port not equal to last-grantee wins; last-grantee updates on each grant.
  - A single request always wins.
- Reads: mem_we=0, mem_be all ones.
- Writes: dm_be is passed to mem_be unchanged. dm_ack is still issued after MEM_LAT. dm_rdata is unchanged.
- Fetch port never writes.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack). This is combinational and 0 during reset.
- Inputs are latched at grant. Changes to addr/wdata after grant do not affect the access in flight.
- A request dropped before its ack (protocol violation): the access still completes and ack still pulses.
- rdata registers of the non-winning port are never modified.
- Reset mid-access: all state and outputs clear immediately; the aborted access produces no ack after reset release.

Test Plan:
- Reset: rst=0 during activity -> all outputs 0 asynchronously; after release with no requests, mem_ce stays 0.
- Fetch only, MEM_LAT=2: if_req at cycle 0, if_addr=0x40, memory returns 0x24080001 -> mem_ce=1, mem_addr=0x40 at cycle 1; if_ack at cycle 4 with if_rdata=0x24080001; stall high in cycles 0-3.
- Simultaneous requests, DATA_PRIO=1: dm write addr 0x100, data 0xDEADBEEF, be 4'b1111, plus if read addr 0x44 -> data access issued and acked first; fetch issued in the cycle after dm_ack's DONE+IDLE; if_rdata correct.
- Round-robin, DATA_PRIO=0: both requests held continuously and re-raised after each ack -> grant order I, D, I, D starting with I after reset.
- Byte write: dm_we=1, dm_be=4'b0011, addr 0x200 -> mem_be=4'b0011, mem_we=1 for one cycle; dm_rdata unchanged.
- Reset mid-WAIT (MEM_LAT=4), rst low for 2 cycles, then release -> no ack ever pulses for the aborted access; next request is served normally.
